// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Purpose  : Decode-stage register scoreboard. Keeps a saturating count of
//            in-flight writes for every architectural register, handles NRET
//            retire/squash notifications per cycle and raises the DE stall
//            for RAW hazards and counter saturation.
// Options  : SCB_BYPASS_EN - a retire releases dependent sources in the
//            same cycle (requires register-file write-through).
// Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
  parameter int NREGS     = 32,
  parameter int REGNOBITS = 5,
  parameter int CNTBITS   = 3,
  parameter int NRET      = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         issue_valid_i,
  input  logic                         issue_wr_i,
  input  logic [REGNOBITS-1:0]         issue_dst_i,
  input  logic [REGNOBITS-1:0]         issue_rs1_i,
  input  logic [REGNOBITS-1:0]         issue_rs2_i,
  input  logic                         issue_use_rs1_i,
  input  logic                         issue_use_rs2_i,
  input  logic [NRET-1:0]              retire_valid_i,
  input  logic [NRET*REGNOBITS-1:0]    retire_dst_i,
  input  logic                         flush_i,
  output logic                         stall_o,
  output logic                         issue_accept_o,
  output logic [NREGS-1:0]             busy_o,
  output logic [REGNOBITS+CNTBITS-1:0] pending_cnt_o,
  output logic                         overflow_err_o,
  output logic                         underflow_err_o
);

  // Two guard bits: one for the +1 above CMAX, one as the sign of a
  // decrement below zero.
  localparam int                CW   = CNTBITS + 2;
  localparam int                PW   = REGNOBITS + CNTBITS;
  localparam logic [CW-1:0]     CMAX = CW'((2 ** CNTBITS) - 1);

  logic [CNTBITS-1:0] cnt_q [NREGS];
  logic [CNTBITS-1:0] cnt_d [NREGS];
  logic [NREGS-1:0]   busy_q, busy_d;
  logic [PW-1:0]      pend_q, pend_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic [CW-1:0]      dec   [NREGS];
  logic [CW-1:0]      view  [NREGS];
  logic [NREGS-1:0]   vbusy;
  logic [NREGS-1:0]   vsat;
  logic               hz1, hz2, sat;

  // Count retire ports naming each register this cycle; register 0 is ignored.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      dec[r] = '0;
      for (int k = 0; k < NRET; k++) begin
        if (retire_valid_i[k] && (r != 0) &&
            (retire_dst_i[k*REGNOBITS +: REGNOBITS] == REGNOBITS'(r)))
          dec[r] = dec[r] + CW'(1);
      end
    end
  end

  // Counter value as seen by the hazard check: registered state, or
  // registered state minus this cycle's retires when bypassing.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
`ifdef SCB_BYPASS_EN
      view[r]  = {2'b00, cnt_q[r]} - dec[r];
`else
      view[r]  = {2'b00, cnt_q[r]};
`endif
      vbusy[r] = (view[r] != '0);
      // A retire to the destination this cycle frees a slot, so no saturation.
      vsat[r]  = (view[r] == CMAX) && (dec[r] == '0);
    end
  end

  // Hazard and saturation lookups; out-of-range indices never hazard.
  always_comb begin
    hz1 = 1'b0;
    hz2 = 1'b0;
    sat = 1'b0;
    if (issue_use_rs1_i && (int'(issue_rs1_i) < NREGS))
      hz1 = vbusy[issue_rs1_i];
    if (issue_use_rs2_i && (int'(issue_rs2_i) < NREGS))
      hz2 = vbusy[issue_rs2_i];
    if (issue_wr_i && (issue_dst_i != '0) && (int'(issue_dst_i) < NREGS))
      sat = vsat[issue_dst_i];
    stall_o        = issue_valid_i & ~flush_i & ~reset & (hz1 | hz2 | sat);
    issue_accept_o = issue_valid_i & ~stall_o & ~flush_i & ~reset;
  end

  // Next counter values, busy vector, pending total and sticky error flags.
  always_comb begin
    logic [CW-1:0] nxt;
    logic          inc;
    pend_d = '0;
    busy_d = '0;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    for (int r = 0; r < NREGS; r++) begin
      inc = issue_accept_o & issue_wr_i & (issue_dst_i == REGNOBITS'(r)) & (r != 0);
      nxt = {2'b00, cnt_q[r]} + CW'(inc) - dec[r];
      if (reset || flush_i) begin
        cnt_d[r] = '0;
      end else if (nxt[CW-1]) begin
        cnt_d[r] = '0;
        unf_d    = 1'b1;
      end else if (nxt > CMAX) begin
        cnt_d[r] = CMAX[CNTBITS-1:0];
        ovf_d    = 1'b1;
      end else begin
        cnt_d[r] = nxt[CNTBITS-1:0];
      end
      busy_d[r] = (cnt_d[r] != '0);
      pend_d    = pend_d + PW'(cnt_d[r]);
    end
    if (reset) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  // State register; reset values are produced by the next-state logic.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREGS; r++)
      cnt_q[r] <= cnt_d[r];
    busy_q <= busy_d;
    pend_q <= pend_d;
    ovf_q  <= ovf_d;
    unf_q  <= unf_d;
  end

  assign busy_o          = busy_q;
  assign pending_cnt_o   = pend_q;
  assign overflow_err_o  = ovf_q;
  assign underflow_err_o = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_scoreboard
// Purpose  : Directed bench for reg_scoreboard (CNTBITS=2). Stimulus pushes
//            expected values tagged with the cycle they apply to; a monitor
//            on the falling edge pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;

`ifdef SCB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid_i, issue_wr_i, issue_use_rs1_i, issue_use_rs2_i;
  logic [4:0]  issue_dst_i, issue_rs1_i, issue_rs2_i;
  logic [1:0]  retire_valid_i;
  logic [9:0]  retire_dst_i;
  logic        flush_i;
  logic        stall_o, issue_accept_o;
  logic [31:0] busy_o;
  logic [6:0]  pending_cnt_o;
  logic        overflow_err_o, underflow_err_o;

  reg_scoreboard #(.NREGS(32), .REGNOBITS(5), .CNTBITS(2), .NRET(2)) dut (
    .clk(clk), .reset(reset),
    .issue_valid_i(issue_valid_i), .issue_wr_i(issue_wr_i),
    .issue_dst_i(issue_dst_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_use_rs1_i(issue_use_rs1_i), .issue_use_rs2_i(issue_use_rs2_i),
    .retire_valid_i(retire_valid_i), .retire_dst_i(retire_dst_i),
    .flush_i(flush_i), .stall_o(stall_o), .issue_accept_o(issue_accept_o),
    .busy_o(busy_o), .pending_cnt_o(pending_cnt_o),
    .overflow_err_o(overflow_err_o), .underflow_err_o(underflow_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    int          cyc;
    int          sel;   // 0 stall, 1 accept, 2 busy, 3 pending, 4 ovf, 5 unf
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  localparam int S_STALL = 0, S_ACC = 1, S_BUSY = 2, S_PEND = 3, S_OVF = 4, S_UNF = 5;

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.sel)
        S_STALL: act = {31'd0, stall_o};
        S_ACC:   act = {31'd0, issue_accept_o};
        S_BUSY:  act = busy_o;
        S_PEND:  act = {25'd0, pending_cnt_o};
        S_OVF:   act = {31'd0, overflow_err_o};
        default: act = {31'd0, underflow_err_o};
      endcase
      n_checks++;
      if (e.cyc != cyc || act !== e.exp) begin
        n_errors++;
        $display("FAIL %s cyc=%0d (due %0d) got=%0h want=%0h", e.name, cyc, e.cyc, act, e.exp);
      end
    end
  end

  task automatic push(input string n, input int off, input int sel, input logic [31:0] v);
    sb.push_back('{n, cyc + off, sel, v});
  endtask

  task automatic comb(input string n, input bit st, input bit acc);
    push({n, ".stall"}, 0, S_STALL, {31'd0, st});
    push({n, ".accept"}, 0, S_ACC, {31'd0, acc});
  endtask

  task automatic regs(input string n, input logic [31:0] b, input int p);
    push({n, ".busy"}, 1, S_BUSY, b);
    push({n, ".pend"}, 1, S_PEND, 32'(p));
  endtask

  task automatic drv(input bit v, input bit wr, input int dst,
                     input int r1, input bit u1, input int r2, input bit u2,
                     input bit [1:0] rv, input int d0, input int d1, input bit fl);
    issue_valid_i   = v;
    issue_wr_i      = wr;
    issue_dst_i     = 5'(dst);
    issue_rs1_i     = 5'(r1);
    issue_use_rs1_i = u1;
    issue_rs2_i     = 5'(r2);
    issue_use_rs2_i = u2;
    retire_valid_i  = rv;
    retire_dst_i    = {5'(d1), 5'(d0)};
    flush_i         = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    tick();
    // Reset holds off accept even with a valid write issue.
    drv(1, 1, 5, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    comb("rst", 0, 0);
    regs("rst", 32'h0, 0);
    push("rst.ovf", 1, S_OVF, 0);
    push("rst.unf", 1, S_UNF, 0);
    tick();
    reset = 1'b0;

    // Issue write x5.
    drv(1, 1, 5, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    comb("x5_wr", 0, 1);
    regs("x5_wr", 32'h1 << 5, 1);
    tick();
    // RAW on x5, no retire.
    drv(1, 0, 0, 5, 1, 0, 0, 2'b00, 0, 0, 0);
    comb("x5_raw", 1, 0);
    regs("x5_raw", 32'h1 << 5, 1);
    tick();
    // Retire x5 in the same cycle as the dependent issue.
    drv(1, 0, 0, 5, 1, 0, 0, 2'b01, 5, 0, 0);
    comb("x5_ret", !BYP, BYP);
    regs("x5_ret", 32'h0, 0);
    tick();
    drv(1, 0, 0, 5, 1, 0, 0, 2'b00, 0, 0, 0);
    comb("x5_free", 0, 1);
    tick();

    // Issue and retire x3 in the same cycle net to no change.
    drv(1, 1, 3, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    comb("x3_wr", 0, 1);
    regs("x3_wr", 32'h1 << 3, 1);
    tick();
    drv(1, 1, 3, 0, 0, 0, 0, 2'b01, 3, 0, 0);
    comb("x3_both", 0, 1);
    regs("x3_both", 32'h1 << 3, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 3, 0);
    regs("x3_ret", 32'h0, 0);
    tick();

    // Register 0: issue, sources and retire are all ignored.
    drv(1, 1, 0, 0, 1, 0, 1, 2'b11, 0, 0, 0);
    comb("x0", 0, 1);
    regs("x0", 32'h0, 0);
    push("x0.unf", 1, S_UNF, 0);
    tick();

    // Saturate x7 at CMAX=3.
    for (int i = 1; i <= 3; i++) begin
      drv(1, 1, 7, 0, 0, 0, 0, 2'b00, 0, 0, 0);
      comb($sformatf("x7_wr%0d", i), 0, 1);
      regs($sformatf("x7_wr%0d", i), 32'h1 << 7, i);
      tick();
    end
    drv(1, 1, 7, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    comb("x7_sat", 1, 0);
    regs("x7_sat", 32'h1 << 7, 3);
    push("x7_sat.ovf", 1, S_OVF, 0);
    tick();
    // Both ports retire x7 together.
    drv(0, 0, 0, 0, 0, 0, 0, 2'b11, 7, 7, 0);
    regs("x7_ret2", 32'h1 << 7, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 2'b01, 7, 0, 0);
    regs("x7_ret1", 32'h0, 0);
    push("x7_ret1.unf", 1, S_UNF, 0);
    tick();

    // Underflow on x9 is sticky.
    drv(0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 9, 0);
    regs("x9_unf", 32'h0, 0);
    push("x9_unf.unf", 1, S_UNF, 1);
    tick();

    // Build x4=2, x6=1, then flush with a concurrent write to x8.
    drv(1, 1, 4, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    comb("x4_a", 0, 1);
    tick();
    drv(1, 1, 4, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    comb("x4_b", 0, 1);
    tick();
    drv(1, 1, 6, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    comb("x6", 0, 1);
    regs("x46", (32'h1 << 4) | (32'h1 << 6), 3);
    push("x46.unf", 1, S_UNF, 1);
    tick();
    drv(1, 1, 8, 4, 1, 0, 0, 2'b01, 4, 0, 1);
    comb("flush", 0, 0);
    regs("flush", 32'h0, 0);
    push("flush.unf", 1, S_UNF, 1);
    tick();

    // Reset clears the sticky flag.
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    push("rst2.unf", 1, S_UNF, 0);
    regs("rst2", 32'h0, 0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
      n_errors += sb.size();
      n_checks += sb.size();
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
Parametrised register scoreboard for the decode stage.
- Tracks outstanding writes per architectural register with saturating pending counters.
- Accepts NRET simultaneous retire (write-back/squash) notifications per cycle.
- Produces the DE stall decision for RAW hazards and counter saturation.
- Replaces the single-writeback busy-bit logic, removing negedge updates; all state updates on posedge clk.

Parameters:
NREGS, 32, number of architectural registers; register 0 is never tracked
REGNOBITS, 5, register index width; must satisfy 2**REGNOBITS >= NREGS
CNTBITS, 3, width of each per-register pending counter; max count CMAX = 2**CNTBITS-1
NRET, 2, number of retire ports

Ports:
clk  input  1  clock; all state changes on posedge
reset  input  1  synchronous, active-high
issue_valid_i  input  1  DE holds a valid instruction this cycle
issue_wr_i  input  1  instruction writes issue_dst_i
issue_dst_i  input  REGNOBITS  destination register
issue_rs1_i  input  REGNOBITS  source 1 index
issue_rs2_i  input  REGNOBITS  source 2 index
issue_use_rs1_i  input  1  source 1 is read
issue_use_rs2_i  input  1  source 2 is read
retire_valid_i  input  NRET  per-port retire strobe; covers completed and squashed writers
retire_dst_i  input  NRET*REGNOBITS  per-port destination; port k at bits [k*REGNOBITS +: REGNOBITS]
flush_i  input  1  clear all tracking; used on full pipeline drain
stall_o  output  1  combinational; DE must hold its instruction
issue_accept_o  output  1  combinational; issue counted this cycle
busy_o  output  NREGS  registered; bit r = (cnt[r] != 0)
pending_cnt_o  output  REGNOBITS+CNTBITS  registered sum of all counters
overflow_err_o  output  1  sticky; increment attempted at CMAX
underflow_err_o  output  1  sticky; decrement below zero requested

Behaviour:
- Reset:
  - All cnt[r] = 0; busy_o = 0; pending_cnt_o = 0; both error flags = 0.
  - issue_accept_o = 0 and stall_o = 0 while reset is high.
- Register 0:
  - cnt[0] is held at 0.
  - Issue and retire naming 0 are ignored.
  - A source of 0 is never busy.
- Effective source busy, src_busy(x):
  - Default: cnt[x] != 0, from registered state.
  - Retire in cycle N becomes visible to stall in cycle N+1.
- stall_o = issue_valid_i & ~flush_i & ~reset & (hz1 | hz2 | sat).
  - hz1 = issue_use_rs1_i & src_busy(rs1); hz2 likewise for rs2.
  - sat = issue_wr_i & dst != 0 & cnt[dst] == CMAX & no retire to dst this cycle.
- issue_accept_o = issue_valid_i & ~stall_o & ~flush_i & ~reset.
- Per-register update (not flushing):
  - inc = issue_accept_o & issue_wr_i & dst == r & r != 0.
  - dec = number of ports k with retire_valid_i[k] & retire_dst_i[k] == r.
  - cnt_next = cnt + inc - dec, computed at CNTBITS+2 width.
  - Result < 0: clamp to 0 and set underflow_err_o.
  - Result > CMAX: hold at CMAX and set overflow_err_o. Unreachable while stall rules are honoured.
- Simultaneous issue and retire to the same register net both changes in one cycle.
  - Example: cnt 1, inc 1, dec 1 -> cnt stays 1.
- Multiple ports retiring the same register in one cycle each decrement it.
- pending_cnt_o next = sum over r of cnt_next[r]; incremental maintenance permitted if equivalent.
- flush_i:
  - Next cycle all counters are 0 and pending_cnt_o = 0.
  - Issue and retire inputs that cycle are ignored.
  - Error flags are kept; only reset clears them.
- Reset mid-operation overrides flush, issue and retire.

Optional Feature:
SCB_BYPASS_EN:
- Defined: src_busy(x) = (cnt[x] - dec[x]) != 0.
  - A retire in cycle N releases a dependent source in the same cycle N.
  - The WB value must be forwarded by the register file write-through path.
  - sat likewise uses cnt - dec.
- Undefined: registered-state semantics described above; one extra stall cycle per RAW hazard.

Test Plan:
- Reset, then issue wr x5 (valid, use none) -> accept=1; next cycle busy_o[5]=1, pending_cnt_o=1.
- x5 pending; issue rs1=x5 -> stall_o=1. Retire port0 dst=5 in cycle N:
  - Without bypass: stall drops in N+1.
  - With SCB_BYPASS_EN: stall=0 in cycle N.
- Same cycle: accepted issue wr x3 and retire x3 with cnt[3]=1 -> cnt[3] stays 1; pending_cnt_o unchanged.
- CNTBITS=2: issue wr x7 three times -> cnt=3; fourth issue wr x7 -> stall_o=1, overflow_err_o stays 0. Retire x7 on both ports same cycle -> cnt=1.
- Retire x9 with cnt[9]=0 -> cnt stays 0; underflow_err_o=1 until reset.
- cnt[4]=2, cnt[6]=1; assert flush_i with a concurrent issue wr x8 -> next cycle busy_o=0, pending_cnt_o=0, issue_accept_o was 0.
